// File: rtl/lpf_stream_if.sv
// Bus bundle for lpf_stream: read-only frame-buffer port plus the pixel stream
// handed to the projective transform.
interface lpf_stream_if #(
    parameter int LOG_WIDTH  = 10,
    parameter int LOG_HEIGHT = 9,
    parameter int PIX_W      = 18,
    parameter int MEM_W      = 36
);
    logic                  mem_rd_req;
    logic [LOG_WIDTH-1:0]  mem_x;
    logic [LOG_HEIGHT-1:0] mem_y;
    logic                  mem_done;
    logic [MEM_W-1:0]      mem_data;

    logic                  request;
    logic                  ready;
    logic [PIX_W-1:0]      pixel;
    logic [LOG_WIDTH-1:0]  x_out;
    logic [LOG_HEIGHT-1:0] y_out;
    logic                  pixel_flag;

    modport master (
        output mem_rd_req, mem_x, mem_y, ready, pixel, x_out, y_out, pixel_flag,
        input  mem_done, mem_data, request
    );

    modport slave (
        input  mem_rd_req, mem_x, mem_y, ready, pixel, x_out, y_out, pixel_flag,
        output mem_done, mem_data, request
    );
endinterface

// File: rtl/lpf_stream.sv
// Raster-order pixel streamer: unpacks frame-buffer words and emits one pixel per
// request, either raw, [1 2 1]/4 horizontally filtered, or as a test pattern.
module lpf_stream #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int LOG_WIDTH    = 10,
    parameter int LOG_HEIGHT   = 9,
    parameter int CHANNELS     = 3,
    parameter int CH_W         = 6,
    parameter int PPW          = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_flag,
    input  logic [1:0]   mode,
    lpf_stream_if.master bus
);
    localparam int PIX_W = CHANNELS * CH_W;
    localparam int MEM_W = PPW * PIX_W;
    localparam int CNT_W = $clog2(PPW + 1);
    localparam int SUM_W = CH_W + 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] STEP  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam logic [LOG_WIDTH-1:0]  X_LAST   = LOG_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [LOG_HEIGHT-1:0] Y_LAST   = LOG_HEIGHT'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(PPW);

    logic [2:0]            state;
    logic [1:0]            mode_reg;
    logic [LOG_WIDTH-1:0]  ox, fx, fx_nxt, tx;
    logic [LOG_HEIGHT-1:0] oy, fy, fy_nxt;
    logic [MEM_W-1:0]      wbuf;
    logic [CNT_W-1:0]      wcnt;
    logic [PIX_W-1:0]      win_l, win_c, win_r;
    logic [PIX_W-1:0]      fl, fc, fr, filt, emit_pix;
    logic [SUM_W-1:0]      sum;
    logic                  need, need_after, last_pix;

    logic                  rd_req_q, flag_q;
    logic [LOG_WIDTH-1:0]  mem_x_q, x_out_q;
    logic [LOG_HEIGHT-1:0] mem_y_q, y_out_q;
    logic [PIX_W-1:0]      pixel_q;

    // tx is the furthest column that must already sit in the window before EMIT
    always_comb begin
        tx = ox;
        if (mode_reg == 2'd1 && ox != X_LAST)
            tx = ox + LOG_WIDTH'(1);
        fx_nxt = (fx == X_LAST) ? '0 : fx + LOG_WIDTH'(1);
        fy_nxt = fy;
        if (fx == X_LAST)
            fy_nxt = (fy == Y_LAST) ? '0 : fy + LOG_HEIGHT'(1);
    end

    assign need       = (fy == oy) && (fx <= tx);
    assign need_after = (fy_nxt == oy) && (fx_nxt <= tx);
    assign last_pix   = (ox == X_LAST) && (oy == Y_LAST);

    // At row end the window has already shifted past ox: centre is r, left is c
    always_comb begin
        fl = (ox == X_LAST || ox == '0) ? win_c : win_l;
        fc = (ox == X_LAST) ? win_r : win_c;
        fr = win_r;
        filt = '0;
        sum  = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            sum = {2'b00, fl[ch*CH_W +: CH_W]} + {1'b0, fc[ch*CH_W +: CH_W], 1'b0}
                + {2'b00, fr[ch*CH_W +: CH_W]} + SUM_W'(2);
            filt[ch*CH_W +: CH_W] = sum[SUM_W-1:2];
        end
    end

    always_comb begin
        case (mode_reg)
            2'd1:    emit_pix = filt;
            2'd2:    emit_pix = {PIX_W{ox[3]}};
            default: emit_pix = win_r;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode_reg <= 2'd0;
            ox       <= '0;
            oy       <= '0;
            fx       <= '0;
            fy       <= '0;
            wbuf     <= '0;
            wcnt     <= '0;
            win_l    <= '0;
            win_c    <= '0;
            win_r    <= '0;
            rd_req_q <= 1'b0;
            flag_q   <= 1'b0;
            mem_x_q  <= '0;
            mem_y_q  <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            pixel_q  <= '0;
        end else begin
            rd_req_q <= 1'b0;
            flag_q   <= 1'b0;
            if (frame_flag) begin
                ox       <= '0;
                oy       <= '0;
                fx       <= '0;
                fy       <= '0;
                wcnt     <= '0;
                mode_reg <= mode;
                state    <= ((state == FETCH || state == DRAIN) && !bus.mem_done) ? DRAIN : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.request)
                            state <= (mode_reg == 2'd2) ? EMIT : STEP;
                    end
                    STEP: begin
                        if (!need) begin
                            state <= EMIT;
                        end else if (wcnt == '0) begin
                            state    <= FETCH;
                            rd_req_q <= 1'b1;
                            mem_x_q  <= fx - LOG_WIDTH'(int'(fx) % PPW);
                            mem_y_q  <= fy;
                        end else begin
                            win_l <= win_c;
                            win_c <= win_r;
                            win_r <= wbuf[MEM_W-1 -: PIX_W];
                            wbuf  <= wbuf << PIX_W;
                            wcnt  <= wcnt - CNT_W'(1);
                            fx    <= fx_nxt;
                            fy    <= fy_nxt;
                            state <= need_after ? STEP : EMIT;
                        end
                    end
                    FETCH: begin
                        if (bus.mem_done) begin
                            wbuf  <= bus.mem_data;
                            wcnt  <= CNT_FULL;
                            state <= STEP;
                        end
                    end
                    EMIT: begin
                        pixel_q <= emit_pix;
                        x_out_q <= ox;
                        y_out_q <= oy;
                        flag_q  <= 1'b1;
                        if (ox == X_LAST) begin
                            ox <= '0;
                            oy <= (oy == Y_LAST) ? '0 : oy + LOG_HEIGHT'(1);
                        end else begin
                            ox <= ox + LOG_WIDTH'(1);
                        end
                        if (last_pix) begin
                            fx   <= '0;
                            fy   <= '0;
                            wcnt <= '0;
                        end
                        state <= IDLE;
                    end
                    DRAIN: begin
                        if (bus.mem_done)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ready      = (state == IDLE);
    assign bus.mem_rd_req = rd_req_q;
    assign bus.mem_x      = mem_x_q;
    assign bus.mem_y      = mem_y_q;
    assign bus.pixel      = pixel_q;
    assign bus.x_out      = x_out_q;
    assign bus.y_out      = y_out_q;
    assign bus.pixel_flag = flag_q;
endmodule

// File: tb/tb_lpf_stream.sv
// Directed bench for lpf_stream on a 16x4 frame, 3x6-bit pixels, two pixels per word.
module tb_lpf_stream;
    localparam int W     = 16;
    localparam int H     = 4;
    localparam int LW    = 4;
    localparam int LH    = 2;
    localparam int CH    = 3;
    localparam int CW    = 6;
    localparam int PPW   = 2;
    localparam int PIX_W = CH * CW;
    localparam int MEM_W = PPW * PIX_W;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_flag;
    logic [1:0] mode;

    lpf_stream_if #(.LOG_WIDTH(LW), .LOG_HEIGHT(LH), .PIX_W(PIX_W), .MEM_W(MEM_W)) bus ();

    lpf_stream #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .LOG_WIDTH   (LW),
        .LOG_HEIGHT  (LH),
        .CHANNELS    (CH),
        .CH_W        (CW),
        .PPW         (PPW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .frame_flag(frame_flag),
        .mode      (mode),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    logic [CW-1:0]    img [0:H-1][0:W-1];
    int               n_vec = 0;
    int               n_err = 0;
    logic [PIX_W-1:0] r_pix;
    logic [LW-1:0]    r_x, r_mx;
    logic [LH-1:0]    r_y, r_my;
    int               r_lat, r_nrd;

    function automatic logic [PIX_W-1:0] rep(input logic [CW-1:0] v);
        return {v, v, v};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.ready, 1);
        chk({tag, "_rdreq"}, bus.mem_rd_req, 0);
        chk({tag, "_flag"},  bus.pixel_flag, 0);
        chk({tag, "_pixel"}, bus.pixel, 0);
        chk({tag, "_xout"},  bus.x_out, 0);
        chk({tag, "_yout"},  bus.y_out, 0);
        chk({tag, "_memx"},  bus.mem_x, 0);
        chk({tag, "_memy"},  bus.mem_y, 0);
    endtask

    task automatic pulse_frame(input logic [1:0] m);
        mode       = m;
        frame_flag = 1'b1;
        @(negedge clock);
        frame_flag = 1'b0;
    endtask

    // Issues one request and serves memory reads after lat cycles; called on a negedge.
    task automatic req_pixel(input int lat);
        int done_at;
        bit got;
        done_at = -1;
        got     = 1'b0;
        r_nrd   = 0;
        r_lat   = -1;
        bus.request = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            bus.request  = 1'b0;
            bus.mem_done = 1'b0;
            if (bus.mem_rd_req) begin
                r_nrd++;
                r_mx    = bus.mem_x;
                r_my    = bus.mem_y;
                done_at = i + lat - 1;
            end
            if (i == done_at) begin
                bus.mem_done = 1'b1;
                bus.mem_data = {rep(img[int'(r_my)][int'(r_mx)]), rep(img[int'(r_my)][int'(r_mx) + 1])};
            end
            if (bus.pixel_flag) begin
                got   = 1'b1;
                r_lat = i;
                r_pix = bus.pixel;
                r_x   = bus.x_out;
                r_y   = bus.y_out;
            end
        end
        bus.mem_done = 1'b0;
        if (!got) chk("req_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rd_i;
        bit  saw_flag, saw_rd;

        reset        = 1'b1;
        frame_flag   = 1'b0;
        mode         = 2'd0;
        bus.request  = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = CW'(y * W + x);
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Bypass: miss then hit in the same word
        req_pixel(3);
        chk("byp0_lat", r_lat, 6);
        chk("byp0_pix", r_pix, rep(6'd0));
        chk("byp0_x", r_x, 0);
        chk("byp0_nrd", r_nrd, 1);
        chk("byp0_memx", r_mx, 0);
        req_pixel(2);
        chk("byp1_lat", r_lat, 2);
        chk("byp1_pix", r_pix, rep(6'd1));
        chk("byp1_x", r_x, 1);
        chk("byp1_nrd", r_nrd, 0);

        // Remainder of the frame, then one pixel past the frame end
        for (int k = 2; k < W * H; k++) begin
            req_pixel(1 + k % 3);
            chk("wrap_pix", r_pix, rep(img[k / W][k % W]));
            chk("wrap_x", r_x, k % W);
            chk("wrap_y", r_y, k / W);
        end
        req_pixel(2);
        chk("wrapx_x", r_x, 0);
        chk("wrapx_y", r_y, 0);
        chk("wrapx_pix", r_pix, rep(img[0][0]));
        chk("wrapx_nrd", r_nrd, 1);
        chk("wrapx_memx", r_mx, 0);
        chk("wrapx_memy", r_my, 0);

        // Filter on row 0
        for (int x = 0; x < W; x++) img[0][x] = '0;
        img[0][0] = 6'd8;  img[0][1] = 6'd16; img[0][2] = 6'd40; img[0][3] = 6'd20;
        img[0][13] = 6'd50; img[0][14] = 6'd60; img[0][15] = 6'd63;
        pulse_frame(2'd1);
        req_pixel(3);
        chk("flt0_pix", r_pix, rep(6'd10));
        chk("flt0_x", r_x, 0);
        chk("flt0_lat", r_lat, 7);
        req_pixel(2);
        chk("flt1_pix", r_pix, rep(6'd20));
        mode = 2'd2;
        req_pixel(1);
        chk("flt2_pix", r_pix, rep(6'd29));
        chk("flt2_lat", r_lat, 2);
        mode = 2'd0;
        for (int k = 3; k < 14; k++) req_pixel(1);
        chk("flt13_x", r_x, 13);
        chk("flt13_pix", r_pix, rep(6'd40));
        req_pixel(1);
        chk("flt14_pix", r_pix, rep(6'd58));
        req_pixel(1);
        chk("flt15_pix", r_pix, rep(6'd62));
        chk("flt15_lat", r_lat, 2);
        chk("flt15_nrd", r_nrd, 0);

        // frame_flag during an outstanding read, stale completion afterwards
        for (int x = 0; x < W; x++) img[0][x] = CW'(x);
        pulse_frame(2'd0);
        rd_i     = -1;
        saw_flag = 1'b0;
        bus.request = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            bus.request  = 1'b0;
            frame_flag   = 1'b0;
            bus.mem_done = 1'b0;
            if (bus.mem_rd_req && rd_i < 0) rd_i = i;
            if (bus.pixel_flag) saw_flag = 1'b1;
            if (rd_i >= 0 && i == rd_i + 1) frame_flag = 1'b1;
            if (rd_i >= 0 && (i == rd_i + 2 || i == rd_i + 3)) chk("drain_busy", bus.ready, 0);
            if (rd_i >= 0 && i == rd_i + 3) begin
                bus.mem_done = 1'b1;
                bus.mem_data = '1;
            end
            if (rd_i >= 0 && i == rd_i + 4) chk("drain_idle", bus.ready, 1);
        end
        bus.mem_done = 1'b0;
        chk("drain_rd_seen", rd_i >= 0, 1);
        chk("drain_noflag", saw_flag, 0);
        req_pixel(2);
        chk("drain_next_nrd", r_nrd, 1);
        chk("drain_next_memx", r_mx, 0);
        chk("drain_next_memy", r_my, 0);
        chk("drain_next_pix", r_pix, rep(6'd0));

        // frame_flag cancels a pixel already in EMIT
        saw_flag = 1'b0;
        bus.request = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus.request = 1'b0;
            frame_flag  = (i == 1);
            if (bus.pixel_flag) saw_flag = 1'b1;
        end
        frame_flag = 1'b0;
        chk("cancel_noflag", saw_flag, 0);

        // frame_flag wins over a coincident request; also latches test-pattern mode
        saw_flag = 1'b0;
        saw_rd   = 1'b0;
        mode        = 2'd2;
        frame_flag  = 1'b1;
        bus.request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            frame_flag  = 1'b0;
            bus.request = 1'b0;
            if (bus.pixel_flag) saw_flag = 1'b1;
            if (bus.mem_rd_req) saw_rd = 1'b1;
        end
        mode = 2'd0;
        chk("coinc_noflag", saw_flag, 0);
        chk("coinc_nord", saw_rd, 0);

        for (int k = 0; k < W; k++) begin
            req_pixel(1);
            chk("tp_pix", r_pix, (k >= 8) ? {PIX_W{1'b1}} : '0);
            chk("tp_x", r_x, k);
            chk("tp_nrd", r_nrd, 0);
        end

        // Reset in the middle of a fetch, completion arriving afterwards
        pulse_frame(2'd0);
        req_pixel(1);
        req_pixel(1);
        saw_flag = 1'b0;
        rd_i     = -1;
        bus.request = 1'b1;
        for (int i = 0; i < 10 && rd_i < 0; i++) begin
            @(negedge clock);
            bus.request = 1'b0;
            if (bus.mem_rd_req) rd_i = i;
        end
        chk("rst_rd_seen", rd_i >= 0, 1);
        chk("rst_memx_pre", bus.mem_x, 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_data = '1;
        @(negedge clock);
        bus.mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.pixel_flag) saw_flag = 1'b1;
        end
        chk("rst_noflag", saw_flag, 0);
        chk_reset_outputs("rstmid");
        req_pixel(2);
        chk("rst_next_x", r_x, 0);
        chk("rst_next_memx", r_mx, 0);
        chk("rst_next_pix", r_pix, rep(6'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lpf_stream.md
Name: lpf_stream

Overview:
- Streams pixels in raster order from the frame-buffer memory interface to the projective transform, one pixel per consumer request.
- Unpacks PPW pixels from each memory word.
- Per-frame mode selects bypass, a horizontal 3-tap [1 2 1]/4 low-pass filter applied per channel, or a test pattern.
- Read-only client of the memory interface: no write path.

Parameters:
IMAGE_WIDTH, 640, columns per frame; must be a multiple of PPW
IMAGE_HEIGHT, 480, rows per frame
LOG_WIDTH, 10, x coordinate width
LOG_HEIGHT, 9, y coordinate width
CHANNELS, 3, colour channels per pixel
CH_W, 6, bits per channel
PPW, 2, pixels per memory word (PPW >= 1)
Derived: PIX_W = CHANNELS*CH_W; MEM_W = PPW*PIX_W

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
frame_flag  in  1  one-cycle pulse: restart at (0,0); latch mode
mode  in  2  0 bypass, 1 filter, 2 test pattern, 3 treated as bypass
mem_rd_req  out  1  one-cycle read request pulse
mem_x  out  LOG_WIDTH  word-aligned column of requested word
mem_y  out  LOG_HEIGHT  row of requested word
mem_done  in  1  one-cycle pulse; mem_data valid this cycle
mem_data  in  MEM_W  packed word; lowest column in MSBs
request  in  1  consumer pixel request, honoured only while ready=1
ready  out  1  high when a request will be accepted
pixel  out  PIX_W  output pixel
x_out  out  LOG_WIDTH  column of pixel
y_out  out  LOG_HEIGHT  row of pixel
pixel_flag  out  1  one-cycle pulse: pixel/x_out/y_out valid

Behaviour:
- Reset values:
  - state=IDLE; ready=1; mem_rd_req=0; pixel_flag=0.
  - pixel, x_out, y_out, mem_x, mem_y = 0.
  - mode_reg=0 (bypass); word buffer empty.
  - Output position (ox,oy) and fetch position (fx,fy) = (0,0).
- States:
  - IDLE: ready=1. Accepting a request moves to STEP; in mode 2 it moves to EMIT.
  - STEP: consumes one pixel from the word buffer into the window {l,c,r}, shifting l<=c, c<=r, r<=new; fx advances.
    - Buffer empty: go to FETCH instead.
    - More pixels needed: stay in STEP.
    - Otherwise: go to EMIT.
  - FETCH: mem_rd_req=1 on the entry cycle only, with mem_x=fx rounded down to a PPW multiple and mem_y=fy. Waits for mem_done, loads the buffer, returns to STEP.
  - EMIT: registers the output. pixel_flag=1 and ready=1 on the following cycle (IDLE). ox/oy advance.
  - DRAIN: entered when frame_flag arrives during FETCH after mem_rd_req was issued. Discards the next mem_done, then goes to IDLE.
- Pixels required before EMIT:
  - Bypass: column ox.
  - Filter: column ox+1, or column ox when ox=IMAGE_WIDTH-1. Row start therefore needs two STEPs.
- Filter arithmetic, per channel:
  - out = (L + 2C + R + 2) >> 2, computed at CH_W+2 bits, truncated to CH_W bits; no saturation needed.
  - Edge replication: L=C at ox=0; R=C at ox=IMAGE_WIDTH-1.
- Test pattern: pixel = PIX_W copies of ox[3]; no memory traffic.
- Latency, request accepted at cycle t:
  - Buffer hit, one STEP: pixel_flag at t+2.
  - Filter at row end (zero STEPs): pixel_flag at t+2.
  - Miss: mem_rd_req at t+1; with mem_done at d, pixel_flag at d+2.
  - Two STEPs: add one cycle each.
- Wrap-around:
  - x advances to 0 after IMAGE_WIDTH-1 and y increments.
  - After (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) both positions wrap to (0,0) and the buffer is cleared.
- frame_flag, any state:
  - Positions and buffer cleared; mode_reg<=mode.
  - Any in-flight EMIT is cancelled (no pixel_flag).
  - Next state: IDLE, or DRAIN if a read is outstanding.
  - frame_flag coincident with request: frame_flag wins and the request is ignored.
- mode changes between frame_flag pulses have no effect.
- Requests while ready=0 are ignored, not queued.
- Reset mid-fetch: immediate return to the reset state; a later mem_done is ignored in IDLE.

Test Plan:
- Bypass, PPW=2: word {A,B} returned 3 cycles after mem_rd_req (issued t+1). Two requests -> pixel A at (0,0) on pixel_flag at t+6; pixel B at (1,0) two cycles after the second request; exactly one mem_rd_req, with mem_x=0.
- Filter, one channel: row 0 values 8,16,40,... -> out(0)=(8+16+16+2)>>2=10; out(1)=(8+32+40+2)>>2=20. Last column is replicated: values 60,63 -> (60+126+63+2)>>2=62.
- Row/frame wrap: request IMAGE_WIDTH*IMAGE_HEIGHT+1 pixels -> x_out returns to 0 with y_out incremented at each row end; the final extra pixel reports (0,0) and mem_x=0, mem_y=0.
- frame_flag one cycle after mem_rd_req, stale mem_done 4 cycles later -> stale data discarded; state goes DRAIN then IDLE; next request fetches (0,0).
- Mode 2, ox=8..15 -> pixel=all ones; ox=0..7 -> pixel zero; mem_rd_req stays 0.
- Reset asserted mid-FETCH, then mem_done pulsed -> all outputs at reset values; no pixel_flag.
